// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SRAM controller port among NUM_REQ requesters, with a watchdog.
// Latency: grant one cycle after req is sampled; ack one cycle after mem_ready. Losers hold req until served.
module sram_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_rw,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ-1:0]        req_burst_en,
  input  logic [NUM_REQ*3-1:0]      req_burst_len,
  input  logic [NUM_REQ*128-1:0]    req_burst_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      ack_err,
  output logic [DATA_W-1:0]         rdata,
  output logic [2:0]                grant_id,
  output logic                      busy,
  output logic                      timeout_sticky,
  output logic                      mem_req,
  output logic                      mem_rw,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_data_in,
  output logic                      mem_burst_en,
  output logic [2:0]                mem_burst_len,
  output logic [127:0]              mem_burst_data,
  input  logic [DATA_W-1:0]         mem_data_out,
  input  logic                      mem_ready
);

  typedef enum logic [1:0] {ARB_IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    wd_cnt;
  logic [2:0]          rr_ptr;
  logic [7:0]          req_pad;
  logic [3:0]          idx;
  logic [2:0]          pick;
  logic                pick_vld;
  logic                timeout_hit;
  logic [NUM_REQ-1:0]  grant_oh;

  logic                sel_rw;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_burst_en;
  logic [2:0]          sel_burst_len;
  logic [127:0]        sel_burst_data;

  // First set request at or above rr_ptr, wrapping to 0.
  always_comb begin
    req_pad = '0;
    req_pad[NUM_REQ-1:0] = req;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr} + 4'(k);
      if (idx >= 4'(NUM_REQ)) idx = idx - 4'(NUM_REQ);
      if (!pick_vld && req_pad[idx[2:0]]) begin
        pick_vld = 1'b1;
        pick     = idx[2:0];
      end
    end
  end

  always_comb begin
    sel_rw         = 1'b0;
    sel_addr       = '0;
    sel_wdata      = '0;
    sel_burst_en   = 1'b0;
    sel_burst_len  = '0;
    sel_burst_data = '0;
    grant_oh       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_oh[i] = (grant_id == 3'(i));
      if (pick == 3'(i)) begin
        sel_rw         = req_rw[i];
        sel_addr       = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata      = req_wdata[i*DATA_W +: DATA_W];
        sel_burst_en   = req_burst_en[i];
        sel_burst_len  = req_burst_len[i*3 +: 3];
        sel_burst_data = req_burst_data[i*128 +: 128];
      end
    end
  end

  assign timeout_hit = (wd_cnt == WD_LAST);
  assign mem_req     = (state == ISSUE);
  assign busy        = (state != ARB_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: if (pick_vld) state_nxt = ISSUE;
      ISSUE:    state_nxt = WAIT;
      WAIT:     if (mem_ready || timeout_hit) state_nxt = RESP;
      RESP:     state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ARB_IDLE;
    else          state <= state_nxt;
  end

  // ack/ack_err are loaded on the WAIT exit so they are high exactly during RESP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt         <= '0;
      rr_ptr         <= '0;
      grant_id       <= '0;
      ack            <= '0;
      ack_err        <= 1'b0;
      rdata          <= '0;
      timeout_sticky <= 1'b0;
      mem_rw         <= 1'b0;
      mem_addr       <= '0;
      mem_data_in    <= '0;
      mem_burst_en   <= 1'b0;
      mem_burst_len  <= '0;
      mem_burst_data <= '0;
    end else begin
      ack     <= '0;
      ack_err <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (pick_vld) begin
            grant_id       <= pick;
            mem_rw         <= sel_rw;
            mem_addr       <= sel_addr;
            mem_data_in    <= sel_wdata;
            mem_burst_en   <= sel_burst_en;
            mem_burst_len  <= sel_burst_len;
            mem_burst_data <= sel_burst_data;
          end
        end
        ISSUE: wd_cnt <= '0;
        WAIT: begin
          wd_cnt <= wd_cnt + CNT_W'(1);
          if (mem_ready) begin
            rdata <= mem_data_out;
            ack   <= grant_oh;
          end else if (timeout_hit) begin
            rdata          <= '0;
            ack            <= grant_oh;
            ack_err        <= 1'b1;
            timeout_sticky <= 1'b1;
          end
        end
        RESP: rr_ptr <= (grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id + 3'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: table of single transactions plus round-robin, timeout and reset sequences.
module tb_sram_arbiter;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [3:0]   req = '0, req_rw = '0, req_burst_en = '0;
  logic [31:0]  req_addr = '0;
  logic [63:0]  req_wdata = '0;
  logic [11:0]  req_burst_len = '0;
  logic [511:0] req_burst_data = '0;
  logic [3:0]   ack;
  logic         ack_err, busy, timeout_sticky, mem_req, mem_rw, mem_burst_en;
  logic [15:0]  rdata, mem_data_in;
  logic [15:0]  mem_data_out = '0;
  logic         mem_ready = 1'b0;
  logic [2:0]   grant_id, mem_burst_len;
  logic [7:0]   mem_addr;
  logic [127:0] mem_burst_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(16), .TIMEOUT(15)) dut (
    .clk(clk), .reset_n(reset_n),
    .req(req), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_burst_en(req_burst_en), .req_burst_len(req_burst_len), .req_burst_data(req_burst_data),
    .ack(ack), .ack_err(ack_err), .rdata(rdata), .grant_id(grant_id), .busy(busy),
    .timeout_sticky(timeout_sticky), .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_burst_en(mem_burst_en), .mem_burst_len(mem_burst_len),
    .mem_burst_data(mem_burst_data), .mem_data_out(mem_data_out), .mem_ready(mem_ready)
  );

  // Controller model: ready pulse two cycles after mem_req, plus one per extra burst beat.
  logic [15:0] sram [256];
  bit          preload_done = 1'b0;
  bit          hang = 1'b0;
  int          rdy_cnt = 0;
  logic [2:0]  last;

  always @(negedge clk) begin
    if (!preload_done) begin
      for (int i = 0; i < 256; i++) sram[i] = 16'h0;
      sram[8'h20] = 16'h1234;
      preload_done = 1'b1;
    end
    mem_ready = 1'b0;
    if (rdy_cnt > 0) begin
      rdy_cnt--;
      if (rdy_cnt == 0 && !hang) mem_ready = 1'b1;
    end
    if (mem_req) begin
      last = mem_burst_en ? mem_burst_len : 3'd0;
      rdy_cnt = 2 + int'(last);
      if (mem_rw) mem_data_out = sram[mem_addr + 8'(last)];
      else begin
        mem_data_out = 16'h0;
        for (int j = 0; j <= int'(last); j++)
          sram[mem_addr + 8'(j)] = mem_burst_en ? mem_burst_data[j*16 +: 16] : mem_data_in;
      end
    end
  end

  typedef struct {
    int           id;
    logic         rw;
    logic [7:0]   addr;
    logic [15:0]  wdata;
    logic         burst;
    logic [2:0]   len;
    logic [127:0] bdata;
    int           lat;
    logic [15:0]  exp_rdata;
    logic         exp_err;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int n;
    int pulses;
    bit seen;
    @(negedge clk);
    req_rw[v.id] = v.rw;
    req_addr[v.id*8 +: 8] = v.addr;
    req_wdata[v.id*16 +: 16] = v.wdata;
    req_burst_en[v.id] = v.burst;
    req_burst_len[v.id*3 +: 3] = v.len;
    req_burst_data[v.id*128 +: 128] = v.bdata;
    req[v.id] = 1'b1;
    n = 0; pulses = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (mem_req) pulses++;
      if (n == 1) begin
        check("issue_mem_req", mem_req, 1'b1);
        check("issue_mem_addr", mem_addr, v.addr);
        check("issue_mem_rw", mem_rw, v.rw);
        check("issue_mem_data_in", mem_data_in, v.wdata);
        check("issue_burst_en", mem_burst_en, v.burst);
        check("issue_burst_len", mem_burst_len, v.len);
        req_addr[v.id*8 +: 8] = ~v.addr;
      end
      if (n == 2) check("addr_latched", mem_addr, v.addr);
      if (ack != 4'b0) seen = 1'b1;
    end
    check("ack_latency", n, v.lat);
    check("ack_onehot", ack, 4'b0001 << v.id);
    check("ack_err", ack_err, v.exp_err);
    check("rdata", rdata, v.exp_rdata);
    check("grant_id", grant_id, v.id);
    check("mem_req_pulses", pulses, 1);
    req[v.id] = 1'b0;
  endtask

  task automatic wait_ack(output logic [3:0] a, output int n);
    a = '0; n = 0;
    while (a == 4'b0 && n < 30) begin
      @(negedge clk);
      n++;
      a = ack;
    end
  endtask

  function automatic int oh_index(input logic [3:0] a);
    int r = -1;
    for (int i = 0; i < 4; i++) if (a == (4'b0001 << i)) r = i;
    return r;
  endfunction

  initial begin
    logic [3:0] a;
    int n;
    int w;
    int exp_order [6];
    bit saw_ack;
    vec_t tv;

    vecs[0] = '{0, 1'b0, 8'h10, 16'hA5A5, 1'b0, 3'd0, 128'h0, 4, 16'h0000, 1'b0};
    vecs[1] = '{2, 1'b1, 8'h20, 16'h0000, 1'b0, 3'd0, 128'h0, 4, 16'h1234, 1'b0};
    vecs[2] = '{1, 1'b0, 8'h40, 16'h0000, 1'b1, 3'd3, 128'h0004_0003_0002_0001, 7, 16'h0000, 1'b0};
    vecs[3] = '{3, 1'b1, 8'h42, 16'h0000, 1'b0, 3'd0, 128'h0, 4, 16'h0003, 1'b0};
    vecs[4] = '{0, 1'b1, 8'h40, 16'h0000, 1'b1, 3'd1, 128'h0, 5, 16'h0002, 1'b0};
    vecs[5] = '{1, 1'b1, 8'h10, 16'h0000, 1'b0, 3'd0, 128'h0, 4, 16'hA5A5, 1'b0};
    exp_order = '{0, 1, 2, 3, 0, 3};

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_ack", ack, 4'b0);
    check("rst_ack_err", ack_err, 1'b0);
    check("rst_rdata", rdata, 16'h0);
    check("rst_grant_id", grant_id, 3'd0);
    check("rst_sticky", timeout_sticky, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, 8'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);
    for (int i = 0; i < 4; i++) check("burst_sram", sram[8'h40 + 8'(i)], 16'(i + 1));
    check("sticky_before_timeout", timeout_sticky, 1'b0);

    // Timeout, then a normal transaction.
    hang = 1'b1;
    tv = '{2, 1'b1, 8'h20, 16'h0000, 1'b0, 3'd0, 128'h0, 17, 16'h0000, 1'b1};
    run_txn(tv);
    check("timeout_sticky", timeout_sticky, 1'b1);
    hang = 1'b0;
    tv = '{3, 1'b1, 8'h20, 16'h0000, 1'b0, 3'd0, 128'h0, 4, 16'h1234, 1'b0};
    run_txn(tv);
    check("sticky_held", timeout_sticky, 1'b1);

    // Round-robin from rr_ptr=0: all four, then 4'b1001.
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    req_rw = 4'hF; req_burst_en = 4'h0;
    req_addr = 32'h2020_2020;
    req = 4'hF;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) req = 4'b1001;
      wait_ack(a, n);
      w = oh_index(a);
      check("rr_order", w, exp_order[k]);
      if (w >= 0) req[w] = 1'b0;
    end
    req = 4'h0;

    // Asynchronous reset in WAIT of a long burst read.
    tv = '{1, 1'b1, 8'h40, 16'h0000, 1'b1, 3'd7, 128'h0, 0, 16'h0, 1'b0};
    @(negedge clk);
    req_rw[1] = 1'b1; req_burst_en[1] = 1'b1; req_burst_len[5:3] = tv.len;
    req_addr[15:8] = tv.addr; req[1] = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_reset_busy", busy, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_mem_req", mem_req, 1'b0);
    check("reset_ack", ack, 4'b0);
    check("reset_mem_addr", mem_addr, 8'h0);
    req = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    saw_ack = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ack != 4'b0 || busy) saw_ack = 1'b1;
    end
    check("no_ack_after_reset", saw_ack, 1'b0);
    tv = '{0, 1'b1, 8'h43, 16'h0000, 1'b0, 3'd0, 128'h0, 4, 16'h0004, 1'b0};
    run_txn(tv);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Round-robin arbiter that shares one sram_controller CPU-side port between NUM_REQ requesters (CPU, DMA, debug, etc.).
- Latches the winning requester's command and issues exactly one single-cycle mem_req.
- Waits for mem_ready, then returns read data and a one-cycle ack to the winner.
- Includes a watchdog that aborts a transaction when mem_ready never arrives.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 8, address width.
- DATA_W, 16, data word width.
- TIMEOUT, 15, maximum WAIT cycles before abort (must exceed 10).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  level request per requester; held until ack.
- req_rw  in  NUM_REQ  1=read, 0=write, per requester.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i uses slice i.
- req_wdata  in  NUM_REQ*DATA_W  packed single-write data.
- req_burst_en  in  NUM_REQ  burst enable per requester.
- req_burst_len  in  NUM_REQ*3  burst length field; L means L+1 transfers.
- req_burst_data  in  NUM_REQ*128  packed 8x16 burst write data.
- ack  out  NUM_REQ  one-hot one-cycle completion pulse.
- ack_err  out  1  high with ack when the transaction timed out.
- rdata  out  DATA_W  read data, valid while ack is high.
- grant_id  out  3  index of the current or last winner.
- busy  out  1  high in every state except ARB_IDLE.
- timeout_sticky  out  1  set on any timeout; cleared only by reset.
- mem_req  out  1  to controller req; high for exactly one cycle per transaction.
- mem_rw, mem_addr, mem_data_in, mem_burst_en, mem_burst_len, mem_burst_data  out  to controller; registered copies of the winner's fields.
- mem_data_out  in  DATA_W  controller read data.
- mem_ready  in  1  controller completion pulse.

Behaviour:
- Reset (reset_n low, async):
  - state=ARB_IDLE, rr_ptr=0, grant_id=0.
  - All outputs 0: ack, ack_err, rdata, busy, timeout_sticky, mem_req and all mem_* fields.
  - Reset mid-transaction abandons it; no ack is issued.
- State machine (ARB_IDLE, ISSUE, WAIT, RESP):
  - ARB_IDLE: if any req bit is set, select the first set bit scanning from rr_ptr upward with wrap to 0. Latch that requester's fields into the mem_* registers, set grant_id, go to ISSUE. With no request, stay.
  - ISSUE: mem_req=1 for this cycle only. Clear the watchdog counter. Go to WAIT.
  - WAIT: mem_req=0 and the counter increments each cycle.
    - If mem_ready: capture mem_data_out into rdata, go to RESP with err=0.
    - Else if counter==TIMEOUT-1: go to RESP with err=1, set timeout_sticky, rdata=0.
  - RESP: ack[grant_id]=1 and ack_err=err for one cycle. rr_ptr=(grant_id+1) mod NUM_REQ. Go to ARB_IDLE.
- Requester must deassert req in the cycle after it sees ack. A req still high in ARB_IDLE is treated as a new request.
- Changes to requester fields after the grant are ignored; fields are latched at grant.
- Requests arriving while busy are held off, not dropped.
- Fairness: a continuously requesting master waits at most NUM_REQ-1 transactions.
- Latency:
  - Req sampled at edge E: ISSUE in E+1..E+2, mem_ready in cycle E+3 for a single transfer, ack in cycle E+4.
  - A burst with length L adds L cycles.
  - Minimum spacing between transactions is 5 cycles.
- Burst read: rdata returns the last word only, matching controller behaviour.
- A mem_ready arriving outside WAIT is ignored.
- grant_id is zero-extended to 3 bits.

Test Plan:
- Single write: reset, req[0]=1, rw=0, addr=8'h10, wdata=16'hA5A5 -> one mem_req pulse, mem_addr=8'h10, mem_data_in=16'hA5A5; ack=4'b0001 exactly 4 cycles after req sampled; ack_err=0.
- Single read: SRAM model preloaded with 16'h1234 at 8'h20; req[2] read -> rdata=16'h1234 with ack=4'b0100; grant_id=2.
- Round-robin: req=4'b1111 held, each requester drops req after its ack -> grant order 0,1,2,3; then req=4'b1001 with rr_ptr=0 -> grant order 0 then 3.
- Burst: req[1] burst write, len=3'd3, data words 1..4 to base 8'h40 -> ack 3 cycles later than a single transfer; SRAM holds 1,2,3,4 at 8'h40..8'h43.
- Timeout: controller model never raises mem_ready -> after 15 WAIT cycles ack with ack_err=1, timeout_sticky=1 and rdata=0; the next request is served normally.
- Reset in WAIT: assert reset_n=0 asynchronously mid-burst -> busy=0 and mem_req=0 immediately; no ack is emitted.
